// File: rtl/pipeline_pkg.sv
// Shared pipeline types: default DMEM widths, arbiter FSM states and read-return tags.
package pipeline_pkg;

   localparam int unsigned DMEM_ADDR_WIDTH = 32;
   localparam int unsigned DMEM_DATA_WIDTH = 64;

   typedef enum logic {
      CORE_PRI  = 1'b0,
      EXT_FORCE = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_CORE = 2'd1,
      TAG_EXT  = 2'd2
   } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: core has fixed priority, ext is forced in after STARVE_LIMIT
// denied cycles; 1-cycle read data is routed back to whichever requester issued the read.
module dmem_arbiter
   import pipeline_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DMEM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  core_req,
   input  logic                  core_we,
   input  logic [ADDR_WIDTH-1:0] core_addr,
   input  logic [DATA_WIDTH-1:0] core_wdata,
   output logic                  core_gnt,
   output logic                  core_stall,
   output logic                  core_rvalid,
   output logic [DATA_WIDTH-1:0] core_rdata,

   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   output logic                  ext_gnt,
   output logic                  ext_rvalid,
   output logic [DATA_WIDTH-1:0] ext_rdata,

   output logic                  dmem_en,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_address,
   output logic [DATA_WIDTH-1:0] dmem_dataIn,
   input  logic [DATA_WIDTH-1:0] dmem_dataOut
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t       state;
   rd_tag_t          rd_tag;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_inc;

   assign starve_inc = CNT_W'(starve_cnt + CNT_W'(1));

   // Grant selection; in EXT_FORCE core only wins if ext has dropped its request.
   always_comb begin
      core_gnt = 1'b0;
      ext_gnt  = 1'b0;
      if (!rst) begin
         if (state == EXT_FORCE && ext_req) begin
            ext_gnt = 1'b1;
         end else if (core_req) begin
            core_gnt = 1'b1;
         end else if (ext_req) begin
            ext_gnt = 1'b1;
         end
      end
   end

   assign core_stall = core_req & ~core_gnt & ~rst;
   assign dmem_en    = core_gnt | ext_gnt;

   // Winner's access onto the DMEM bus, zero when idle.
   always_comb begin
      dmem_we      = 1'b0;
      dmem_address = '0;
      dmem_dataIn  = '0;
      if (core_gnt) begin
         dmem_we      = core_we;
         dmem_address = core_addr;
         dmem_dataIn  = core_wdata;
      end else if (ext_gnt) begin
         dmem_we      = ext_we;
         dmem_address = ext_addr;
         dmem_dataIn  = ext_wdata;
      end
   end

   // Read return; gated by rst so a tag from the cycle before reset never surfaces.
   assign core_rvalid = ~rst & (rd_tag == TAG_CORE);
   assign ext_rvalid  = ~rst & (rd_tag == TAG_EXT);
   assign core_rdata  = core_rvalid ? dmem_dataOut : '0;
   assign ext_rdata   = ext_rvalid  ? dmem_dataOut : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CORE_PRI;
         starve_cnt <= '0;
         rd_tag     <= TAG_NONE;
      end else begin
         case (state)
            CORE_PRI: begin
               if (ext_req && !ext_gnt) begin
                  starve_cnt <= starve_inc;
                  if (starve_inc == LIMIT) begin
                     state <= EXT_FORCE;
                  end
               end else begin
                  starve_cnt <= '0;
               end
            end
            EXT_FORCE: begin
               state      <= CORE_PRI;
               starve_cnt <= '0;
            end
            default: begin
               state      <= CORE_PRI;
               starve_cnt <= '0;
            end
         endcase

         if (core_gnt && !core_we) begin
            rd_tag <= TAG_CORE;
         end else if (ext_gnt && !ext_we) begin
            rd_tag <= TAG_EXT;
         end else begin
            rd_tag <= TAG_NONE;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle DMEM and a STARVE_LIMIT=1 twin.
module tb_dmem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_req, core_we, ext_req, ext_we;
   logic [AW-1:0] core_addr, ext_addr;
   logic [DW-1:0] core_wdata, ext_wdata;

   logic          core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid;
   logic [DW-1:0] core_rdata, ext_rdata;
   logic          dmem_en, dmem_we;
   logic [AW-1:0] dmem_address;
   logic [DW-1:0] dmem_dataIn, dmem_dataOut;

   logic          c1_gnt, c1_stall, c1_rvalid, e1_gnt, e1_rvalid;
   logic [DW-1:0] c1_rdata, e1_rdata;
   logic          d1_en, d1_we;
   logic [AW-1:0] d1_address;
   logic [DW-1:0] d1_dataIn;
   logic [DW-1:0] d1_dataOut = '0;

   logic [DW-1:0] mem [0:255];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_address(dmem_address),
      .dmem_dataIn(dmem_dataIn), .dmem_dataOut(dmem_dataOut)
   );

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(c1_gnt), .core_stall(c1_stall), .core_rvalid(c1_rvalid), .core_rdata(c1_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(e1_gnt), .ext_rvalid(e1_rvalid), .ext_rdata(e1_rdata),
      .dmem_en(d1_en), .dmem_we(d1_we), .dmem_address(d1_address),
      .dmem_dataIn(d1_dataIn), .dmem_dataOut(d1_dataOut)
   );

   // Single-port memory, read data registered one cycle after the strobe.
   always @(posedge clk) begin
      if (dmem_en) begin
         if (dmem_we) mem[dmem_address[7:0]] <= dmem_dataIn;
         else         dmem_dataOut <= mem[dmem_address[7:0]];
      end
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      ext_req  = 1'b0; ext_we  = 1'b0; ext_addr  = '0; ext_wdata  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 64'hA5;
      dmem_dataOut = '0;
      idle_inputs();
      rst = 1'b1;
      next_cycle();

      // Reset: outputs held at zero even with both requesters active.
      core_req = 1'b1; core_addr = 32'h10; ext_req = 1'b1; ext_addr = 32'h20;
      @(negedge clk);
      check("rst_core_gnt",  64'(core_gnt), 64'd0);
      check("rst_ext_gnt",   64'(ext_gnt), 64'd0);
      check("rst_stall",     64'(core_stall), 64'd0);
      check("rst_dmem_en",   64'(dmem_en), 64'd0);
      check("rst_dmem_addr", 64'(dmem_address), 64'd0);
      check("rst_rvalid",    64'({core_rvalid, ext_rvalid}), 64'd0);
      next_cycle();
      rst = 1'b0;
      idle_inputs();

      // 1: core-only read of 0x10.
      core_req = 1'b1; core_addr = 32'h10;
      @(negedge clk);
      check("t1_core_gnt",  64'(core_gnt), 64'd1);
      check("t1_ext_gnt",   64'(ext_gnt), 64'd0);
      check("t1_stall",     64'(core_stall), 64'd0);
      check("t1_dmem_en",   64'(dmem_en), 64'd1);
      check("t1_dmem_we",   64'(dmem_we), 64'd0);
      check("t1_dmem_addr", 64'(dmem_address), 64'h10);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t1_core_rvalid", 64'(core_rvalid), 64'd1);
      check("t1_core_rdata",  core_rdata, 64'hA5);
      check("t1_ext_rvalid",  64'(ext_rvalid), 64'd0);
      check("t1_idle_en",     64'(dmem_en), 64'd0);
      next_cycle();

      // 2: ext write 0x20 <= 0x1234 then read it back.
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 64'h1234;
      @(negedge clk);
      check("t2_wr_ext_gnt", 64'(ext_gnt), 64'd1);
      check("t2_wr_dmem_we", 64'(dmem_we), 64'd1);
      check("t2_wr_dataIn",  dmem_dataIn, 64'h1234);
      check("t2_wr_addr",    64'(dmem_address), 64'h20);
      next_cycle();
      ext_we = 1'b0; ext_wdata = '0;
      @(negedge clk);
      check("t2_rd_ext_gnt",   64'(ext_gnt), 64'd1);
      check("t2_wr_no_rvalid", 64'(ext_rvalid), 64'd0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t2_ext_rvalid",  64'(ext_rvalid), 64'd1);
      check("t2_ext_rdata",   ext_rdata, 64'h1234);
      check("t2_core_rvalid", 64'(core_rvalid), 64'd0);
      next_cycle();
      @(negedge clk);
      check("t2_rvalid_drop", 64'(ext_rvalid), 64'd0);
      next_cycle();

      // 4: core read then ext read back to back; rdata must not cross.
      core_req = 1'b1; core_addr = 32'h10;
      @(negedge clk);
      check("t4_core_gnt", 64'(core_gnt), 64'd1);
      next_cycle();
      idle_inputs();
      ext_req = 1'b1; ext_addr = 32'h20;
      @(negedge clk);
      check("t4_ext_gnt",      64'(ext_gnt), 64'd1);
      check("t4_core_rvalid",  64'(core_rvalid), 64'd1);
      check("t4_core_rdata",   core_rdata, 64'hA5);
      check("t4_ext_rvalid0",  64'(ext_rvalid), 64'd0);
      check("t4_ext_rdata0",   ext_rdata, 64'd0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t4_ext_rvalid",   64'(ext_rvalid), 64'd1);
      check("t4_ext_rdata",    ext_rdata, 64'h1234);
      check("t4_core_rvalid0", 64'(core_rvalid), 64'd0);
      check("t4_core_rdata0",  core_rdata, 64'd0);
      next_cycle();

      // 3: continuous contention (4 core : 1 ext); 6: ext drops while forced (i == 14).
      for (int i = 0; i < 20; i++) begin
         core_req = 1'b1; core_we = 1'b1; core_addr = 32'h30; core_wdata = 64'(i);
         ext_req  = (i != 14); ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 64'(i + 100);
         @(negedge clk);
         if (i < 10) begin
            check("t3_core_gnt", 64'(core_gnt), 64'((i % 5) != 4));
            check("t3_ext_gnt",  64'(ext_gnt),  64'((i % 5) == 4));
            check("t3_stall",    64'(core_stall), 64'((i % 5) == 4));
            check("t3_addr",     64'(dmem_address), ((i % 5) == 4) ? 64'h40 : 64'h30);
            check("lim1_ext_gnt",  64'(e1_gnt), 64'((i % 2) == 1));
            check("lim1_core_gnt", 64'(c1_gnt), 64'((i % 2) == 0));
         end else begin
            check("t6_core_gnt", 64'(core_gnt), 64'(i != 19));
            check("t6_ext_gnt",  64'(ext_gnt),  64'(i == 19));
            check("t6_stall",    64'(core_stall), 64'(i == 19));
         end
         next_cycle();
      end
      idle_inputs();

      // 5: reset the cycle after a core read grant.
      core_req = 1'b1; core_addr = 32'h10;
      @(negedge clk);
      check("t5_core_gnt", 64'(core_gnt), 64'd1);
      next_cycle();
      rst = 1'b1; ext_req = 1'b1; ext_addr = 32'h40;
      @(negedge clk);
      check("t5_rst_rvalid", 64'(core_rvalid), 64'd0);
      check("t5_rst_rdata",  core_rdata, 64'd0);
      check("t5_rst_gnts",   64'({core_gnt, ext_gnt}), 64'd0);
      check("t5_rst_en",     64'({dmem_en, dmem_we, core_stall}), 64'd0);
      next_cycle();
      rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (j == 0) check("t5_no_late_rvalid", 64'(core_rvalid), 64'd0);
         check("t5_post_core_gnt", 64'(core_gnt), 64'(j < 4));
         check("t5_post_ext_gnt",  64'(ext_gnt),  64'(j == 4));
         next_cycle();
      end
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
